// File: rtl/crossbar_switch_pkg.sv
// Shared constants for the crossbar switch slice.
// Slices are packed as index*width +: width throughout.
package crossbar_switch_pkg;

  localparam int unsigned DefaultDw = 8;
  localparam int unsigned DefaultN  = 4;

endpackage

// File: rtl/crossbar_switch_if.sv
// Packed data/select bus between source lanes, the crossbar and sink lanes.
interface crossbar_switch_if
  import crossbar_switch_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned N  = DefaultN
);

  logic [N*DW-1:0] din;
  logic [N*N-1:0]  sel;
  logic [N*DW-1:0] dout;
  logic [N-1:0]    sel_err;

  modport master (
    output din,
    output sel,
    input  dout,
    input  sel_err
  );

  modport slave (
    input  din,
    input  sel,
    output dout,
    output sel_err
  );

endinterface

// File: rtl/crossbar_port_mux.sv
// One N:1 priority mux for a single output lane; err flags a row that is not one-hot.
module crossbar_port_mux
  import crossbar_switch_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned N  = DefaultN
) (
  input  logic [N*DW-1:0] din,
  input  logic [N-1:0]    row,
  output logic [DW-1:0]   data,
  output logic            err
);

  logic found;
  logic multi;

  // Only the winning slice is ever read, so X on unselected inputs cannot leak.
  always_comb begin
    data  = '0;
    found = 1'b0;
    multi = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (row[j]) begin
        if (!found) begin
          data  = din[j*DW +: DW];
          found = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
    end
    err = !found || multi;
  end

endmodule

// File: rtl/crossbar_switch.sv
// Registered NxN data crossbar: per-output priority one-hot select, one cycle latency.
module crossbar_switch
  import crossbar_switch_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned N  = DefaultN
) (
  input logic              clk,
  input logic              rst,
  crossbar_switch_if.slave bus
);

  logic [N*DW-1:0] dout_d, dout_q;
  logic [N-1:0]    err_d, err_q;

  for (genvar i = 0; i < N; i++) begin : g_port
    crossbar_port_mux #(
      .DW(DW),
      .N (N)
    ) u_mux (
      .din (bus.din),
      .row (bus.sel[i*N +: N]),
      .data(dout_d[i*DW +: DW]),
      .err (err_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      err_q  <= '0;
    end else begin
      dout_q <= dout_d;
      err_q  <= err_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.sel_err = err_q;

endmodule

// File: tb/tb_crossbar_switch.sv
// Scoreboard bench for crossbar_switch (DW=8, N=4).
module tb_crossbar_switch;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;

  typedef struct packed {
    logic [N*DW-1:0] dout;
    logic [N-1:0]    err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  crossbar_switch_if #(.DW(DW), .N(N)) bus ();

  crossbar_switch #(
    .DW(DW),
    .N (N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: lowest set bit wins, flag anything whose popcount is not 1.
  function automatic exp_t model(input logic [N*DW-1:0] d, input logic [N*N-1:0] s);
    exp_t e;
    logic [N-1:0] row;
    e = '0;
    for (int i = 0; i < N; i++) begin
      row = s[i*N +: N];
      for (int j = N - 1; j >= 0; j--) begin
        if (row[j]) e.dout[i*DW +: DW] = d[j*DW +: DW];
      end
      e.err[i] = ($countones(row) != 1);
    end
    return e;
  endfunction

  task automatic step_exp(input string tag, input logic [N*DW-1:0] d, input logic [N*N-1:0] s,
                          input logic r, input exp_t e);
    exp_t got;
    @(negedge clk);
    bus.din = d;
    bus.sel = s;
    rst     = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check({tag, "_dout"}, 32'(bus.dout), 32'(got.dout));
      check({tag, "_err"}, 32'(bus.sel_err), 32'(got.err));
    end
  endtask

  task automatic step(input string tag, input logic [N*DW-1:0] d, input logic [N*N-1:0] s,
                      input logic r);
    exp_t e;
    e = r ? '0 : model(d, s);
    step_exp(tag, d, s, r, e);
  endtask

  localparam logic [N*DW-1:0] DinBase = 32'h1312_1110;

  initial begin
    logic [N*DW-1:0] d;
    logic [N*N-1:0]  s;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    bus.din = '0;
    bus.sel = '0;

    // Reset held two cycles with arbitrary inputs
    step_exp("rst0", 32'hdead_beef, 16'h1234, 1'b1, '0);
    step_exp("rst1", 32'hcafe_f00d, 16'h8421, 1'b1, '0);

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        step($sformatf("clr_o%0d_i%0d", i, j), DinBase, '0, 1'b0);
        s = '0;
        s[i*N +: N] = 4'(1 << j);
        step($sformatf("sweep_o%0d_i%0d", i, j), DinBase, s, 1'b0);
      end
    end

    step_exp("bcast", DinBase, 16'h4444, 1'b0, '{dout: 32'h1212_1212, err: 4'h0});
    // out0 row 1000 ... out3 row 0001
    step_exp("perm", DinBase, 16'h1248, 1'b0, '{dout: 32'h1011_1213, err: 4'h0});
    step_exp("illegal", DinBase, 16'h1160, 1'b0, '{dout: 32'h1010_1100, err: 4'h3});

    // Back-to-back: sel every cycle, din every other cycle, reset mid-stream
    d = DinBase;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) d = $urandom;
      s = 16'($urandom);
      step($sformatf("b2b%0d", k), d, s, (k == 20 || k == 21));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
